// File: rtl/can_pkg.sv
// Shared definitions for the CAN form checker: frame-field codes, FSM states and
// EOF defaults.
package can_pkg;

    localparam int         FIELD_W_DEF   = 5;
    localparam logic [4:0] CRC_DELIM_DEF = 5'b10001;
    localparam logic [4:0] ACK_DELIM_DEF = 5'b10010;
    localparam logic [4:0] EOF_CODE_DEF  = 5'b10011;
    localparam int         EOF_BITS_DEF  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELIM = 2'd1,
        ST_EOF   = 2'd2,
        ST_LOCK  = 2'd3
    } fsm_state_e;

    // EOF bit index counter: wide enough to hold EOF_BITS (saturation value), never narrower than 4 bits
    function automatic int eof_cnt_w(input int bits);
        int w;
        w = $clog2(bits + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/can_form_checker_if.sv
// Signal bundle for the CAN form checker: bit-stream inputs from the bit timing
// logic and the error reporting outputs.
interface can_form_checker_if #(
    parameter int FIELD_W = 5,
    parameter int COUNT_W = 8
);
    logic               enable;
    logic               sample;
    logic               data;
    logic [FIELD_W-1:0] frame_field;
    logic               clear;
    logic               form_error;
    logic               form_sticky;
    logic [FIELD_W-1:0] err_field;
    logic [COUNT_W-1:0] err_count;

    modport master (
        output enable, sample, data, frame_field, clear,
        input  form_error, form_sticky, err_field, err_count
    );

    modport slave (
        input  enable, sample, data, frame_field, clear,
        output form_error, form_sticky, err_field, err_count
    );
endinterface

// File: rtl/can_sat_counter.sv
// Saturating up-counter; an increment coincident with a clear restarts the count at one.
module can_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            if (clr_i) begin
                count_d = WIDTH'(1);
            end else if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
        end else if (clr_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/can_form_checker.sv
// CAN form checker: flags a dominant bit inside the fixed-form fields (CRC/ACK
// delimiters and EOF), reporting at most one error per frame.
module can_form_checker
    import can_pkg::*;
#(
    parameter int                 FIELD_W         = FIELD_W_DEF,
    parameter logic [FIELD_W-1:0] CRC_DELIM_CODE  = FIELD_W'(CRC_DELIM_DEF),
    parameter logic [FIELD_W-1:0] ACK_DELIM_CODE  = FIELD_W'(ACK_DELIM_DEF),
    parameter logic [FIELD_W-1:0] EOF_CODE        = FIELD_W'(EOF_CODE_DEF),
    parameter int                 EOF_BITS        = EOF_BITS_DEF,
    parameter bit                 IGNORE_LAST_EOF = 1'b1,
    parameter int                 COUNT_W         = 8
) (
    input  logic               i_Clock,
    input  logic               i_Reset_n,
    input  logic               i_Enable,
    input  logic               i_Sample,
    input  logic               i_Data,
    input  logic [FIELD_W-1:0] i_frame_field,
    input  logic               i_Clear,
    output logic               o_form_error,
    output logic               o_form_sticky,
    output logic [FIELD_W-1:0] o_err_field,
    output logic [COUNT_W-1:0] o_err_count
);

    localparam int               CNT_W    = eof_cnt_w(EOF_BITS);
    localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_BITS - 1);
    localparam logic [CNT_W-1:0] EOF_SAT  = CNT_W'(EOF_BITS);

    logic               data_q;
    logic               sample_q;
    logic [FIELD_W-1:0] field_q;

    fsm_state_e         state_q, state_d;
    logic [CNT_W-1:0]   eof_cnt_q, eof_cnt_d;
    logic [CNT_W-1:0]   eof_idx;
    logic               is_delim, is_eof, eof_checked;
    logic               err_det;

    logic               form_err_q;
    logic               sticky_q, sticky_d;
    logic [FIELD_W-1:0] err_field_q, err_field_d;

    function automatic logic [CNT_W-1:0] eof_sat_inc(input logic [CNT_W-1:0] c);
        return (c == EOF_SAT) ? c : c + 1'b1;
    endfunction

    // Input stage: every check below works on these registered copies
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            data_q   <= 1'b0;
            sample_q <= 1'b0;
            field_q  <= '0;
        end else begin
            data_q   <= i_Data;
            sample_q <= i_Sample;
            field_q  <= i_frame_field;
        end
    end

    assign is_delim = (field_q == CRC_DELIM_CODE) || (field_q == ACK_DELIM_CODE);
    assign is_eof   = (field_q == EOF_CODE);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= ST_IDLE;
            eof_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            eof_cnt_q <= eof_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!i_Enable) begin
            state_d = ST_IDLE;
        end else if (sample_q) begin
            case (state_q)
                ST_LOCK: if (!(is_delim || is_eof)) state_d = ST_IDLE;
                default: begin
                    if (err_det)       state_d = ST_LOCK;
                    else if (is_delim) state_d = ST_DELIM;
                    else if (is_eof)   state_d = ST_EOF;
                    else               state_d = ST_IDLE;
                end
            endcase
        end
    end

    // The bit that enters a fixed-form field is itself checked, so detection keys
    // on the sampled field code; the state only supplies LOCK and the EOF index.
    always_comb begin
        eof_idx     = (state_q == ST_EOF) ? eof_cnt_q : '0;
        eof_checked = (eof_idx < EOF_SAT) && !(IGNORE_LAST_EOF && (eof_idx == EOF_LAST));
        err_det     = i_Enable && sample_q && (state_q != ST_LOCK) && !data_q &&
                      (is_delim || (is_eof && eof_checked));
        eof_cnt_d   = '0;
        if (state_d == ST_EOF) begin
            eof_cnt_d = sample_q ? eof_sat_inc(eof_idx) : eof_cnt_q;
        end
        sticky_d    = err_det || (sticky_q && !i_Clear);
        err_field_d = err_det ? field_q : err_field_q;
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            form_err_q  <= 1'b0;
            sticky_q    <= 1'b0;
            err_field_q <= '0;
        end else begin
            form_err_q  <= err_det;
            sticky_q    <= sticky_d;
            err_field_q <= err_field_d;
        end
    end

    can_sat_counter #(
        .WIDTH (COUNT_W)
    ) u_err_count (
        .clk_i   (i_Clock),
        .rst_ni  (i_Reset_n),
        .inc_i   (err_det),
        .clr_i   (i_Clear),
        .count_o (o_err_count)
    );

    assign o_form_error  = form_err_q;
    assign o_form_sticky = sticky_q;
    assign o_err_field   = err_field_q;

endmodule

// File: tb/tb_can_form_checker.sv
// Directed bench for can_form_checker: two instances (last EOF bit ignored / checked)
// driven with the same bit stream.
module tb_can_form_checker;

    localparam logic [4:0] F_CRC_D = 5'b10001;
    localparam logic [4:0] F_ACK_D = 5'b10010;
    localparam logic [4:0] F_EOF   = 5'b10011;
    localparam logic [4:0] F_ACK_S = 5'b10000;
    localparam logic [4:0] F_IFS   = 5'b10100;
    localparam logic [4:0] F_DATA  = 5'b01000;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   pulses0, pulses1;
    int   base0, base1;

    can_form_checker_if #(.FIELD_W(5), .COUNT_W(8)) bus0 ();
    can_form_checker_if #(.FIELD_W(5), .COUNT_W(8)) bus1 ();

    assign bus1.enable      = bus0.enable;
    assign bus1.sample      = bus0.sample;
    assign bus1.data        = bus0.data;
    assign bus1.frame_field = bus0.frame_field;
    assign bus1.clear       = bus0.clear;

    can_form_checker u_dut0 (
        .i_Clock       (clk),
        .i_Reset_n     (rst_n),
        .i_Enable      (bus0.enable),
        .i_Sample      (bus0.sample),
        .i_Data        (bus0.data),
        .i_frame_field (bus0.frame_field),
        .i_Clear       (bus0.clear),
        .o_form_error  (bus0.form_error),
        .o_form_sticky (bus0.form_sticky),
        .o_err_field   (bus0.err_field),
        .o_err_count   (bus0.err_count)
    );

    can_form_checker #(.IGNORE_LAST_EOF(1'b0)) u_dut1 (
        .i_Clock       (clk),
        .i_Reset_n     (rst_n),
        .i_Enable      (bus1.enable),
        .i_Sample      (bus1.sample),
        .i_Data        (bus1.data),
        .i_frame_field (bus1.frame_field),
        .i_Clear       (bus1.clear),
        .o_form_error  (bus1.form_error),
        .o_form_sticky (bus1.form_sticky),
        .o_err_field   (bus1.err_field),
        .o_err_count   (bus1.err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (bus0.form_error === 1'b1) pulses0++;
        if (bus1.form_error === 1'b1) pulses1++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic [4:0] f, input logic d);
        @(negedge clk);
        bus0.frame_field = f;
        bus0.data        = d;
        bus0.sample      = 1'b1;
        @(negedge clk);
        bus0.sample      = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus0.clear = 1'b1;
        @(negedge clk);
        bus0.clear = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pulses0     = 0;
        pulses1     = 0;
        rst_n            = 1'b0;
        bus0.enable      = 1'b1;
        bus0.sample      = 1'b0;
        bus0.data        = 1'b1;
        bus0.frame_field = F_IFS;
        bus0.clear       = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_err",    32'(bus0.form_error),  32'd0);
        chk("rst_sticky", 32'(bus0.form_sticky), 32'd0);
        chk("rst_field",  32'(bus0.err_field),   32'd0);
        chk("rst_count",  32'(bus0.err_count),   32'd0);
        chk("rst_count1", 32'(bus1.err_count),   32'd0);
        rst_n = 1'b1;

        // CRC delimiter dominant: pulse two edges after the sample cycle
        send_bit(F_CRC_D, 1'b0);
        @(negedge clk);
        chk("crc_pulse",  32'(bus0.form_error),  32'd1);
        chk("crc_field",  32'(bus0.err_field),   32'(F_CRC_D));
        chk("crc_count",  32'(bus0.err_count),   32'd1);
        chk("crc_sticky", 32'(bus0.form_sticky), 32'd1);
        @(negedge clk);
        chk("crc_pulse_end", 32'(bus0.form_error), 32'd0);
        send_bit(F_ACK_S, 1'b1);
        pulse_clear();
        chk("clr_sticky", 32'(bus0.form_sticky), 32'd0);
        chk("clr_count",  32'(bus0.err_count),   32'd0);
        chk("clr_field",  32'(bus0.err_field),   32'(F_CRC_D));

        // ACK delimiter error then dominant EOF in the same frame: one error only
        base0 = pulses0;
        send_bit(F_ACK_D, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(F_EOF, 1'b0);
        send_bit(F_IFS, 1'b1);
        @(negedge clk);
        chk("lock_pulses", 32'(pulses0 - base0), 32'd1);
        chk("lock_count",  32'(bus0.err_count),  32'd1);
        chk("lock_field",  32'(bus0.err_field),  32'(F_ACK_D));
        send_bit(F_DATA, 1'b1);
        send_bit(F_CRC_D, 1'b1);
        send_bit(F_ACK_S, 1'b0);
        send_bit(F_ACK_D, 1'b0);
        @(negedge clk);
        chk("frame2_pulse", 32'(bus0.form_error), 32'd1);
        chk("frame2_count", 32'(bus0.err_count),  32'd2);
        for (int i = 0; i < 7; i++) send_bit(F_EOF, 1'b1);
        send_bit(F_IFS, 1'b1);
        chk("frame2_hold", 32'(bus0.err_count), 32'd2);

        // EOF 1111110 then overrun of dominant EOF bits
        pulse_clear();
        base0 = pulses0;
        base1 = pulses1;
        send_bit(F_CRC_D, 1'b1);
        send_bit(F_ACK_S, 1'b0);
        send_bit(F_ACK_D, 1'b1);
        for (int i = 0; i < 6; i++) send_bit(F_EOF, 1'b1);
        send_bit(F_EOF, 1'b0);
        @(negedge clk);
        chk("eof6_chk_pulse", 32'(bus1.form_error), 32'd1);
        chk("eof6_ign_pulse", 32'(bus0.form_error), 32'd0);
        chk("eof6_field",     32'(bus1.err_field),  32'(F_EOF));
        chk("eof6_count",     32'(bus1.err_count),  32'd1);
        for (int i = 0; i < 21; i++) send_bit(F_EOF, 1'b0);
        send_bit(F_IFS, 1'b1);
        @(negedge clk);
        chk("eof_sat_pulses0", 32'(pulses0 - base0), 32'd0);
        chk("eof_sat_pulses1", 32'(pulses1 - base1), 32'd1);
        chk("eof_sat_count0",  32'(bus0.err_count),  32'd0);

        // 300 errors saturate the counter; clear coincident with an error
        pulse_clear();
        for (int i = 0; i < 300; i++) begin
            send_bit(F_CRC_D, 1'b0);
            send_bit(F_ACK_S, 1'b1);
        end
        chk("sat_count0", 32'(bus0.err_count),   32'd255);
        chk("sat_count1", 32'(bus1.err_count),   32'd255);
        chk("sat_sticky", 32'(bus0.form_sticky), 32'd1);
        @(negedge clk);
        bus0.frame_field = F_CRC_D;
        bus0.data        = 1'b0;
        bus0.sample      = 1'b1;
        @(negedge clk);
        bus0.sample      = 1'b0;
        bus0.clear       = 1'b1;
        @(negedge clk);
        bus0.clear       = 1'b0;
        chk("clr_err_pulse",  32'(bus0.form_error),  32'd1);
        chk("clr_err_count",  32'(bus0.err_count),   32'd1);
        chk("clr_err_sticky", 32'(bus0.form_sticky), 32'd1);
        send_bit(F_ACK_S, 1'b1);

        // Disabled: dominant delimiter ignored, status holds
        base0 = pulses0;
        bus0.enable = 1'b0;
        send_bit(F_ACK_D, 1'b0);
        @(negedge clk);
        chk("dis_pulse", 32'(bus0.form_error), 32'd0);
        send_bit(F_EOF, 1'b0);
        send_bit(F_IFS, 1'b1);
        @(negedge clk);
        chk("dis_count",  32'(bus0.err_count),   32'd1);
        chk("dis_sticky", 32'(bus0.form_sticky), 32'd1);
        chk("dis_field",  32'(bus0.err_field),   32'(F_CRC_D));
        bus0.enable = 1'b1;
        // Field change without a sample strobe
        @(negedge clk);
        bus0.frame_field = F_CRC_D;
        bus0.data        = 1'b0;
        repeat (4) @(negedge clk);
        bus0.frame_field = F_IFS;
        bus0.data        = 1'b1;
        repeat (2) @(negedge clk);
        chk("nosample_pulses", 32'(pulses0 - base0), 32'd0);
        chk("nosample_count",  32'(bus0.err_count),  32'd1);

        // Asynchronous reset in the middle of EOF
        send_bit(F_CRC_D, 1'b1);
        send_bit(F_ACK_S, 1'b0);
        send_bit(F_ACK_D, 1'b1);
        send_bit(F_EOF, 1'b1);
        send_bit(F_EOF, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sticky", 32'(bus0.form_sticky), 32'd0);
        chk("arst_count",  32'(bus0.err_count),   32'd0);
        chk("arst_field",  32'(bus0.err_field),   32'd0);
        chk("arst_count1", 32'(bus1.err_count),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_bit(F_IFS, 1'b1);
        send_bit(F_CRC_D, 1'b0);
        @(negedge clk);
        chk("post_rst_pulse", 32'(bus0.form_error), 32'd1);
        chk("post_rst_count", 32'(bus0.err_count),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/can_form_checker.md
CAN_FORM_CHECKER -- requirements
Module: can_form_checker

Interface
REQ-001 SHALL have parameter FIELD_W, default 5: width of the frame-field code.
REQ-002 SHALL have parameter CRC_DELIM_CODE, default 5'b10001: code of the CRC delimiter field.
REQ-003 SHALL have parameter ACK_DELIM_CODE, default 5'b10010: code of the ACK delimiter field.
REQ-004 SHALL have parameter EOF_CODE, default 5'b10011: code of the End-of-Frame field.
REQ-005 SHALL have parameter EOF_BITS, default 7: number of EOF bits.
REQ-006 SHALL have parameter IGNORE_LAST_EOF, default 1: a dominant value in the last EOF bit is not a form error.
REQ-007 SHALL have parameter COUNT_W, default 8: width of the error counter.
REQ-008 SHALL have port i_Clock, input, 1: clock; all logic is rising-edge.
REQ-009 SHALL have port i_Reset_n, input, 1: asynchronous, active-low reset.
REQ-010 SHALL have port i_Enable, input, 1: checking enabled.
REQ-011 SHALL have port i_Sample, input, 1: bit sample-point strobe, one cycle per CAN bit.
REQ-012 SHALL have port i_Data, input, 1: bus bit (1 = recessive).
REQ-013 SHALL have port i_frame_field, input, FIELD_W: current frame-field code.
REQ-014 SHALL have port i_Clear, input, 1: clears the sticky flag and the counter.
REQ-015 SHALL have port o_form_error, output, 1: one-cycle pulse per detected form error.
REQ-016 SHALL have port o_form_sticky, output, 1: set on error, held until i_Clear.
REQ-017 SHALL have port o_err_field, output, FIELD_W: field code of the most recent error.
REQ-018 SHALL have port o_err_count, output, COUNT_W: saturating count of form errors.

Function
REQ-019 SHALL register i_Data, i_frame_field and i_Sample in one input stage; all checks use the registered values.
REQ-020 SHALL run an FSM with states IDLE, DELIM, EOF and LOCK, evaluated only on registered-sample cycles.
REQ-021 IDLE->DELIM when field = CRC_DELIM_CODE or ACK_DELIM_CODE; IDLE->EOF when field = EOF_CODE; any non-LOCK state returns to IDLE when the field is not fixed-form.
REQ-022 In DELIM, a sampled 0 SHALL be a form error and move the FSM to LOCK.
REQ-023 In EOF, a 4-bit-minimum counter SHALL index bits 0..EOF_BITS-1 from 0 and reset on leaving EOF; a sampled 0 at index k SHALL be an error unless IGNORE_LAST_EOF=1 and k=EOF_BITS-1.
REQ-024 If sampling continues in EOF past index EOF_BITS-1, the counter SHALL saturate and no further bits SHALL be checked.
REQ-025 LOCK SHALL suppress further detection (one error per frame) until the sampled field is not fixed-form, then go to IDLE.
REQ-026 On error: o_form_error SHALL pulse high for exactly one cycle, two rising edges after the i_Sample cycle; o_form_sticky SHALL be set; o_err_field SHALL load the field code; o_err_count SHALL increment, saturating at all-ones.
REQ-027 When i_Clear and an error are in the same cycle, the error SHALL win: sticky=1 and count=1.
REQ-028 When i_Enable=0, the FSM SHALL be forced to IDLE and no errors reported; sticky flag, count and o_err_field hold.
REQ-029 A field change with no i_Sample SHALL not advance the FSM.

Reset
REQ-030 While i_Reset_n=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the EOF counter and input registers SHALL be 0; reset mid-frame SHALL discard the frame.
REQ-031 After reset release, checking SHALL start at the next fixed-form field entry.

Structure
REQ-032 Field codes, FSM state encoding and EOF_BITS default SHALL live in shared package can_pkg.
REQ-033 The saturating error counter SHALL be sub-module can_sat_counter (parameter WIDTH, inc/clr inputs).

Verification
REQ-034 CRC delimiter sampled with i_Data=0 -> o_form_error pulse two edges later, o_err_field=5'b10001, count=1.
REQ-035 ACK delimiter 0, then EOF all 0 in the same frame -> exactly one error (LOCK); after the field returns to IDLE, the next frame's ACK delimiter 0 -> count=2.
REQ-036 EOF bits 1111110 with IGNORE_LAST_EOF=1 -> no error; with IGNORE_LAST_EOF=0 -> error at bit 6, o_err_field=5'b10011.
REQ-037 Force 300 errors with COUNT_W=8 -> o_err_count=255; i_Clear coincident with an error -> count=1, sticky=1.
REQ-038 i_Reset_n asserted mid-EOF -> outputs 0 immediately (asynchronous); i_Enable=0 during a dominant delimiter -> no error.
